motoro3_pwm_multich: RTL and testbench
======================================

# motoro3_pwm_multich

Parametrised multi-channel PWM generator for the 3-phase motor drive, sitting between the commutation sequencer (m3cnt / phase enables) and the MOSFET gate outputs. All channels share one period counter. Each channel has its own double-buffered duty register, a per-phase enable, and 0 %/100 % handling. The block adds edge- or center-aligned modulation, a resynchronisation input tied to the commutation step, and an optional minimum-on-time clamp that protects gate drivers against pulses too short to switch.

## Interface
- CNT_W, 9: counter width. PERIOD = 2**CNT_W - 1 (511 clocks at default; 51.1 us at 10 MHz).
- NCH, 3: number of channels (phases A, B, C).
- CENTER, 0: 0 = edge-aligned, 1 = center-aligned (up/down).
- MIN_ON, 32: minimum on-time in clocks, used only when the clamp is compiled in.
- clk  in  1  system clock, 10 MHz.
- rst  in  1  reset, synchronous, active-high. This is the only reset and there is one clock.
- duty_i  in  NCH*CNT_W  requested duty per channel, in clocks of high time per PERIOD; channel i occupies bits [i*CNT_W +: CNT_W].
- duty_ld  in  1  when high, all duty_i channels are written into the shadow registers.
- en_i  in  NCH  per-phase enable (aE/bE/cE).
- sync_i  in  1  period restart strobe, driven from m3cntLast1.
- pwm_o  out  NCH  gate drive, registered.
- prd_o  out  1  one-clock pulse, registered, on the first clock of each period.
- run_o  out  1  high while the FSM is in RUN.

## Operation
- FSM has two states: IDLE and RUN.
  - IDLE: cnt=0, dir=up, pwm_o=0, prd_o=0. Active duty copies shadow duty every clock. Moves to RUN when en_i != 0.
  - RUN: counter runs. Returns to IDLE when en_i == 0. On the IDLE clock, pwm_o drops to 0 on the next edge.
- Shadow duty is loaded on every clock where duty_ld=1. Active duty is loaded from shadow only at a period boundary, on sync_i, or in IDLE. The loaded value is the effective duty after clamping.
- Edge mode:
  - cnt runs 0..PERIOD-1, then wraps to 0.
  - Period boundary is the cnt==PERIOD-1 -> 0 transition.
  - Compare: on = (cnt < duty_act).
- Center mode:
  - cnt runs 0..PERIOD-1 up, then PERIOD-1..0 down. Each value is held twice per period, so the period is 2*PERIOD clocks.
  - Period boundary is after the down-counting 0.
  - Compare: on = (cnt < duty_act). High time is 2*duty_act, centred on the valley.
- pwm_o[i] <= en_i[i] & on[i]. A disabled channel is low; other channels keep running.
- Effective duty (no separate 9'hff-style special case):
  - duty ≥ PERIOD → constant high, with no low clock at the wrap.
  - duty == 0 → constant low.
- sync_i in RUN, takes priority over all other events in the same clock:
  - next clock: cnt=0, dir=up, active duty ← shadow, prd_o=1;
  - if duty_ld is high in the same clock, the new duty_i passes straight through to active.
- duty_ld coinciding with a period boundary: the new value becomes active at that boundary.
- Arithmetic is unsigned, CNT_W bits, with no overflow. The center-mode down count stops at 0.

## Timing
- Reset values: pwm_o=0, prd_o=0, run_o=0, cnt=0, dir=up, shadow=0, active duty=0, state IDLE.
- IDLE→RUN:
  - cnt=0 is valid on the first RUN clock;
  - pwm_o reflects cnt=0 one clock later;
  - prd_o pulses on the first RUN clock.
- Latency cnt → pwm_o: 1 clock, identical for all channels. There is no channel skew.
- prd_o is high for exactly 1 clock per period and on every sync_i restart.
- Reset asserted mid-period forces all reset values on the next edge, regardless of any other input.

## Configuration
- PWM_MIN_ON_CLAMP_EN
  - Defined: any requested duty with 0 < duty < MIN_ON becomes MIN_ON when loaded into active duty. 0 stays 0, and values ≥ MIN_ON pass unchanged.
  - Undefined: duty is used unmodified, and MIN_ON has no effect.

## Test plan
- Reset: rst=1 for 3 clocks with random inputs → pwm_o=0, prd_o=0, run_o=0. After release with en_i=0, the outputs stay 0.
- Edge, duty 0x20 on all channels, en_i=3'b111 → each channel is high for 32 clocks then low for 479. prd_o has a 511-clock spacing. All three channels are edge-aligned.
- Duty update: duty_ld with 0x80 at cnt=100 → the current period keeps 32-clock pulses; the next period has 128-clock pulses. sync_i at cnt=300 → cnt restarts, prd_o pulses, and 128 takes effect immediately.
- Extremes: duty 0 → pwm_o constant 0. Duty 511 → pwm_o constant 1 across ≥3 wraps. en_i=3'b010 → only pwm_o[1] toggles. en_i → 0 → IDLE, pwm_o=0 the next clock.
- Clamp: duty 0x10. With PWM_MIN_ON_CLAMP_EN → 32-clock pulses. Without it → 16-clock pulses. Duty 0 → 0 in both builds.
- CENTER=1, duty 100 → period 1022 clocks, 200 high clocks centred on the cnt=0 valley, prd_o on the first up-count clock.

Source files
------------

// File: rtl/motoro3_pwm_multich.sv
// motoro3_pwm_multich: multi-channel PWM generator for the 3-phase motor drive.
// All channels share one period counter and run edge-aligned (CENTER=0) or
// center-aligned (CENTER=1). Each channel has a shadow duty register and an
// active duty register; active reloads at a period boundary, on sync_i, or in IDLE.
// Optional build macro PWM_MIN_ON_CLAMP_EN: non-zero duties below MIN_ON are
// raised to MIN_ON when they are loaded into the active register.
// Strobe semantics: duty_ld and sync_i are single-clock strobes sampled on every
// rising edge of clk. There is no backpressure. run_o is the FSM state (RUN=1).
module motoro3_pwm_multich #(
    parameter int CNT_W  = 9,
    parameter int NCH    = 3,
    parameter int CENTER = 0,
    parameter int MIN_ON = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH*CNT_W-1:0] duty_i,
    input  logic                 duty_ld,
    input  logic [NCH-1:0]       en_i,
    input  logic                 sync_i,
    output logic [NCH-1:0]       pwm_o,
    output logic                 prd_o,
    output logic                 run_o
);
    localparam int PERIOD = 2**CNT_W - 1;
    localparam logic [CNT_W-1:0] CNT_TOP   = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] DUTY_FULL = CNT_W'(PERIOD);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t           state;
    state_t           nextState;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cntNext;
    logic             cntDown;
    logic             cntDownNext;
    logic             boundary;
    logic             loadActive;
    logic [CNT_W-1:0] shadowDuty [NCH];
    logic [CNT_W-1:0] activeDuty [NCH];
    logic [NCH-1:0]   on;

    // Duty value as it should sit in the active register.
    function automatic logic [CNT_W-1:0] effDuty(input logic [CNT_W-1:0] d);
`ifdef PWM_MIN_ON_CLAMP_EN
        if ((d != '0) && (d < CNT_W'(MIN_ON)))
            effDuty = CNT_W'(MIN_ON);
        else
            effDuty = d;
`else
        // MIN_ON is inert in this build; both arms return the request unchanged.
        effDuty = (MIN_ON >= 0) ? d : d;
`endif
    endfunction

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= nextState;
    end

    // FSM next state: run while any phase is enabled.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (en_i != '0) nextState = RUN;
            RUN:     if (en_i == '0) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Counter stepping and period-boundary detection for both alignment modes.
    always_comb begin
        cntNext     = cnt + 1'b1;
        cntDownNext = cntDown;
        boundary    = 1'b0;
        if (CENTER != 0) begin
            if (!cntDown) begin
                // The top value is held for a second clock while turning around.
                if (cnt == CNT_TOP) begin
                    cntNext     = cnt;
                    cntDownNext = 1'b1;
                end
            end else begin
                cntNext = cnt - 1'b1;
                // The valley is held the same way; the down-counting 0 ends the period.
                if (cnt == '0) begin
                    cntNext     = '0;
                    cntDownNext = 1'b0;
                    boundary    = 1'b1;
                end
            end
        end else if (cnt == CNT_TOP) begin
            cntNext  = '0;
            boundary = 1'b1;
        end
    end

    assign loadActive = (state == IDLE) | sync_i | boundary;
    assign run_o      = (state == RUN);

    // Per-channel compare; a full-scale duty never produces a low clock.
    always_comb begin
        on = '0;
        for (int i = 0; i < NCH; i++)
            on[i] = (activeDuty[i] >= DUTY_FULL) | (cnt < activeDuty[i]);
    end

    // Duty registers, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            cntDown <= 1'b0;
            pwm_o   <= '0;
            prd_o   <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                shadowDuty[i] <= '0;
                activeDuty[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (duty_ld)
                    shadowDuty[i] <= duty_i[i*CNT_W +: CNT_W];
                // A load in the same clock as the active update passes straight through.
                if (loadActive)
                    activeDuty[i] <= effDuty(duty_ld ? duty_i[i*CNT_W +: CNT_W] : shadowDuty[i]);
            end
            if ((state == RUN) && (nextState == RUN)) begin
                pwm_o <= en_i & on;
                if (sync_i) begin
                    cnt     <= '0;
                    cntDown <= 1'b0;
                    prd_o   <= 1'b1;
                end else begin
                    cnt     <= cntNext;
                    cntDown <= cntDownNext;
                    prd_o   <= boundary;
                end
            end else begin
                // IDLE, or leaving RUN: park the counter, outputs low. The first
                // RUN clock starts at cnt=0 with the period pulse.
                cnt     <= '0;
                cntDown <= 1'b0;
                pwm_o   <= '0;
                prd_o   <= (state == IDLE) && (nextState == RUN);
            end
        end
    end

endmodule

// File: tb/tb_motoro3_pwm_multich.sv
// Directed testbench for motoro3_pwm_multich: one edge-aligned and one
// center-aligned instance at default width (CNT_W=9, PERIOD=511).
module tb_motoro3_pwm_multich;

    logic        clk;
    logic        rst;
    logic [26:0] dutyI;
    logic        dutyLd;
    logic [2:0]  enI;
    logic        syncI;
    logic [2:0]  pwm;
    logic        prd;
    logic        run;

    logic [26:0] cDuty;
    logic        cLd;
    logic [2:0]  cEn;
    logic        cSync;
    logic [2:0]  cPwm;
    logic        cPrd;
    logic        cRun;

    int checks   = 0;
    int failures = 0;

    logic [2:0] hist [$];
    logic       prdH [$];

    motoro3_pwm_multich #(.CNT_W(9), .NCH(3), .CENTER(0), .MIN_ON(32)) dutE (
        .clk(clk), .rst(rst), .duty_i(dutyI), .duty_ld(dutyLd), .en_i(enI),
        .sync_i(syncI), .pwm_o(pwm), .prd_o(prd), .run_o(run)
    );

    motoro3_pwm_multich #(.CNT_W(9), .NCH(3), .CENTER(1), .MIN_ON(32)) dutC (
        .clk(clk), .rst(rst), .duty_i(cDuty), .duty_ld(cLd), .en_i(cEn),
        .sync_i(cSync), .pwm_o(cPwm), .prd_o(cPrd), .run_o(cRun)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [26:0] rep(input logic [8:0] d);
        return {d, d, d};
    endfunction

    // Record outputs: index 0 is the current clock, then one tick per index.
    task automatic sample_window(input int n, input bit center);
        hist.delete();
        prdH.delete();
        for (int k = 0; k < n; k++) begin
            if (k > 0) tick();
            hist.push_back(center ? cPwm : pwm);
            prdH.push_back(center ? cPrd : prd);
        end
    endtask

    function automatic int count_hi(input int ch, input int from, input int upto);
        int c = 0;
        for (int k = from; k <= upto; k++) if (hist[k][ch]) c++;
        return c;
    endfunction

    function automatic int count_prd(input int from, input int upto);
        int c = 0;
        for (int k = from; k <= upto; k++) if (prdH[k]) c++;
        return c;
    endfunction

    // Tick until prd pulses on the selected instance, within a budget.
    task automatic wait_prd(input bit center, input int budget);
        int k = 0;
        bit seen = 0;
        while (!seen && k < budget) begin
            tick();
            k++;
            seen = center ? cPrd : prd;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL wait_prd got=timeout exp=pulse within %0d clocks", budget);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            dutyI  = 27'($urandom);
            dutyLd = 1'($urandom_range(0, 1));
            enI    = 3'($urandom_range(1, 7));
            syncI  = 1'($urandom_range(0, 1));
            tick();
        end
        checks++; if (pwm !== 3'b000) begin failures++; $display("FAIL reset_pwm got=%b exp=000", pwm); end
        checks++; if (prd !== 1'b0) begin failures++; $display("FAIL reset_prd got=%b exp=0", prd); end
        checks++; if (run !== 1'b0) begin failures++; $display("FAIL reset_run got=%b exp=0", run); end
        rst = 1'b0; dutyLd = 1'b0; enI = 3'b000; syncI = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if ({pwm, prd, run} !== 5'b0) begin
                failures++;
                $display("FAIL idle_after_reset got=%b exp=00000", {pwm, prd, run});
            end
        end
    endtask

    task automatic test_edge();
        int n;
        int mis = 0;
        dutyI = rep(9'h020); dutyLd = 1'b1; tick();
        dutyLd = 1'b0; enI = 3'b111;
        wait_prd(1'b0, 20);
        checks++; if (run !== 1'b1) begin failures++; $display("FAIL edge_run got=%b exp=1", run); end
        sample_window(1533, 1'b0);
        checks++; if (hist[0] !== 3'b000) begin failures++; $display("FAIL edge_first_clk got=%b exp=000", hist[0]); end
        checks++; if (hist[1] !== 3'b111) begin failures++; $display("FAIL edge_rise got=%b exp=111", hist[1]); end
        checks++; if (hist[32] !== 3'b111) begin failures++; $display("FAIL edge_last_hi got=%b exp=111", hist[32]); end
        checks++; if (hist[33] !== 3'b000) begin failures++; $display("FAIL edge_fall got=%b exp=000", hist[33]); end
        checks++; if (hist[512] !== 3'b111) begin failures++; $display("FAIL edge_rise2 got=%b exp=111", hist[512]); end
        for (int c = 0; c < 3; c++) begin
            n = count_hi(c, 0, 1532);
            checks++; if (n !== 96) begin failures++; $display("FAIL edge_hi_ch%0d got=%0d exp=96", c, n); end
        end
        for (int k = 0; k < 1533; k++) if (hist[k] != 3'b000 && hist[k] != 3'b111) mis++;
        checks++; if (mis !== 0) begin failures++; $display("FAIL edge_align got=%0d exp=0", mis); end
        n = count_prd(0, 1532);
        checks++; if (n !== 3) begin failures++; $display("FAIL edge_prd_count got=%0d exp=3", n); end
        checks++; if (prdH[511] !== 1'b1) begin failures++; $display("FAIL edge_prd_511 got=%b exp=1", prdH[511]); end
        checks++; if (prdH[1022] !== 1'b1) begin failures++; $display("FAIL edge_prd_1022 got=%b exp=1", prdH[1022]); end
    endtask

    task automatic test_duty_update();
        int n;
        wait_prd(1'b0, 600);
        hist.delete(); prdH.delete();
        for (int k = 0; k < 1022; k++) begin
            if (k > 0) tick();
            hist.push_back(pwm); prdH.push_back(prd);
            if (k == 100) begin dutyI = rep(9'h080); dutyLd = 1'b1; end
            if (k == 101) dutyLd = 1'b0;
        end
        for (int c = 0; c < 3; c++) begin
            n = count_hi(c, 0, 510);
            checks++; if (n !== 32) begin failures++; $display("FAIL upd_cur_ch%0d got=%0d exp=32", c, n); end
            n = count_hi(c, 511, 1021);
            checks++; if (n !== 128) begin failures++; $display("FAIL upd_next_ch%0d got=%0d exp=128", c, n); end
        end
        checks++; if (prdH[511] !== 1'b1) begin failures++; $display("FAIL upd_prd got=%b exp=1", prdH[511]); end
    endtask

    task automatic test_sync();
        int n;
        dutyI = rep(9'h020); dutyLd = 1'b1; tick();
        dutyLd = 1'b0;
        wait_prd(1'b0, 600);
        hist.delete(); prdH.delete();
        for (int k = 0; k < 700; k++) begin
            if (k > 0) tick();
            hist.push_back(pwm); prdH.push_back(prd);
            if (k == 100) begin dutyI = rep(9'h080); dutyLd = 1'b1; end
            if (k == 101) dutyLd = 1'b0;
            if (k == 300) syncI = 1'b1;
            if (k == 301) syncI = 1'b0;
            if (k == 600) begin dutyI = rep(9'h040); dutyLd = 1'b1; syncI = 1'b1; end
            if (k == 601) begin dutyLd = 1'b0; syncI = 1'b0; end
        end
        n = count_hi(0, 0, 300);
        checks++; if (n !== 32) begin failures++; $display("FAIL sync_before got=%0d exp=32", n); end
        checks++; if (prdH[301] !== 1'b1) begin failures++; $display("FAIL sync_prd got=%b exp=1", prdH[301]); end
        checks++; if (hist[302] !== 3'b111) begin failures++; $display("FAIL sync_rise got=%b exp=111", hist[302]); end
        checks++; if (hist[429] !== 3'b111) begin failures++; $display("FAIL sync_hi128 got=%b exp=111", hist[429]); end
        checks++; if (hist[430] !== 3'b000) begin failures++; $display("FAIL sync_fall got=%b exp=000", hist[430]); end
        checks++; if (prdH[601] !== 1'b1) begin failures++; $display("FAIL sync_ld_prd got=%b exp=1", prdH[601]); end
        checks++; if (hist[665] !== 3'b111) begin failures++; $display("FAIL sync_ld_hi got=%b exp=111", hist[665]); end
        checks++; if (hist[666] !== 3'b000) begin failures++; $display("FAIL sync_ld_fall got=%b exp=000", hist[666]); end
        n = count_prd(0, 699);
        checks++; if (n !== 3) begin failures++; $display("FAIL sync_prd_count got=%0d exp=3", n); end
    endtask

    task automatic test_boundary_load();
        wait_prd(1'b0, 600);
        for (int k = 0; k < 510; k++) tick();
        dutyI = rep(9'h008); dutyLd = 1'b1;
        tick();
        dutyLd = 1'b0;
        sample_window(12, 1'b0);
        checks++; if (prdH[0] !== 1'b1) begin failures++; $display("FAIL bnd_prd got=%b exp=1", prdH[0]); end
        checks++; if (hist[1] !== 3'b111) begin failures++; $display("FAIL bnd_rise got=%b exp=111", hist[1]); end
        checks++; if (hist[8] !== 3'b111) begin failures++; $display("FAIL bnd_last_hi got=%b exp=111", hist[8]); end
        checks++; if (hist[9] !== 3'b000) begin failures++; $display("FAIL bnd_fall got=%b exp=000", hist[9]); end
    endtask

    task automatic test_extremes();
        int n;
        dutyI = rep(9'd0); dutyLd = 1'b1; syncI = 1'b1; tick();
        dutyLd = 1'b0; syncI = 1'b0;
        sample_window(1100, 1'b0);
        for (int c = 0; c < 3; c++) begin
            n = count_hi(c, 1, 1099);
            checks++; if (n !== 0) begin failures++; $display("FAIL ext_zero_ch%0d got=%0d exp=0", c, n); end
        end
        dutyI = rep(9'd511); dutyLd = 1'b1; syncI = 1'b1; tick();
        dutyLd = 1'b0; syncI = 1'b0;
        sample_window(1600, 1'b0);
        for (int c = 0; c < 3; c++) begin
            n = count_hi(c, 1, 1599);
            checks++; if (n !== 1599) begin failures++; $display("FAIL ext_full_ch%0d got=%0d exp=1599", c, n); end
        end
        n = count_prd(0, 1599);
        checks++; if (n !== 4) begin failures++; $display("FAIL ext_full_wraps got=%0d exp=4", n); end
        dutyI = rep(9'h020); dutyLd = 1'b1; syncI = 1'b1; enI = 3'b010; tick();
        dutyLd = 1'b0; syncI = 1'b0;
        sample_window(1022, 1'b0);
        n = count_hi(1, 1, 1021);
        checks++; if (n !== 64) begin failures++; $display("FAIL ext_en1_ch1 got=%0d exp=64", n); end
        n = count_hi(0, 1, 1021) + count_hi(2, 1, 1021);
        checks++; if (n !== 0) begin failures++; $display("FAIL ext_en1_others got=%0d exp=0", n); end
        tick(); tick();
        checks++; if (pwm !== 3'b010) begin failures++; $display("FAIL ext_en1_hi got=%b exp=010", pwm); end
        enI = 3'b000; tick();
        checks++; if (pwm !== 3'b000) begin failures++; $display("FAIL ext_off_pwm got=%b exp=000", pwm); end
        checks++; if (run !== 1'b0) begin failures++; $display("FAIL ext_off_run got=%b exp=0", run); end
        tick(); tick();
        checks++; if ({pwm, prd, run} !== 5'b0) begin failures++; $display("FAIL ext_idle got=%b exp=00000", {pwm, prd, run}); end
    endtask

    task automatic test_clamp();
        int n;
        int dutyTab [5] = '{16, 1, 31, 32, 0};
`ifdef PWM_MIN_ON_CLAMP_EN
        int expTab [5] = '{32, 32, 32, 32, 0};
`else
        int expTab [5] = '{16, 1, 31, 32, 0};
`endif
        enI = 3'b111;
        wait_prd(1'b0, 20);
        for (int t = 0; t < 5; t++) begin
            dutyI = rep(9'(dutyTab[t])); dutyLd = 1'b1; syncI = 1'b1; tick();
            dutyLd = 1'b0; syncI = 1'b0;
            sample_window(511, 1'b0);
            n = count_hi(2, 1, 510);
            checks++;
            if (n !== expTab[t]) begin
                failures++;
                $display("FAIL clamp_duty%0d got=%0d exp=%0d", dutyTab[t], n, expTab[t]);
            end
        end
    endtask

    task automatic test_center();
        int n;
        cDuty = rep(9'd100); cLd = 1'b1; tick();
        cLd = 1'b0; cEn = 3'b111;
        wait_prd(1'b1, 20);
        checks++; if (cRun !== 1'b1) begin failures++; $display("FAIL ctr_run got=%b exp=1", cRun); end
        sample_window(2044, 1'b1);
        checks++; if (hist[100] !== 3'b111) begin failures++; $display("FAIL ctr_up_hi got=%b exp=111", hist[100]); end
        checks++; if (hist[101] !== 3'b000) begin failures++; $display("FAIL ctr_up_fall got=%b exp=000", hist[101]); end
        checks++; if (hist[922] !== 3'b000) begin failures++; $display("FAIL ctr_dn_lo got=%b exp=000", hist[922]); end
        checks++; if (hist[923] !== 3'b111) begin failures++; $display("FAIL ctr_dn_rise got=%b exp=111", hist[923]); end
        checks++; if (hist[1122] !== 3'b111) begin failures++; $display("FAIL ctr_valley_hi got=%b exp=111", hist[1122]); end
        checks++; if (hist[1123] !== 3'b000) begin failures++; $display("FAIL ctr_valley_fall got=%b exp=000", hist[1123]); end
        for (int c = 0; c < 3; c++) begin
            n = count_hi(c, 1, 1022);
            checks++; if (n !== 200) begin failures++; $display("FAIL ctr_hi_ch%0d got=%0d exp=200", c, n); end
        end
        n = count_prd(0, 2043);
        checks++; if (n !== 2) begin failures++; $display("FAIL ctr_prd_count got=%0d exp=2", n); end
        checks++; if (prdH[1022] !== 1'b1) begin failures++; $display("FAIL ctr_prd_1022 got=%b exp=1", prdH[1022]); end
        cEn = 3'b000;
    endtask

    task automatic test_mid_reset();
        int n;
        dutyI = rep(9'd511); dutyLd = 1'b1; syncI = 1'b1; tick();
        dutyLd = 1'b0; syncI = 1'b0;
        tick(); tick(); tick();
        checks++; if (pwm !== 3'b111) begin failures++; $display("FAIL mid_pre got=%b exp=111", pwm); end
        rst = 1'b1; syncI = 1'b1; dutyLd = 1'b1; dutyI = 27'($urandom); tick();
        checks++; if ({pwm, prd, run} !== 5'b0) begin failures++; $display("FAIL mid_reset got=%b exp=00000", {pwm, prd, run}); end
        rst = 1'b0; syncI = 1'b0; dutyLd = 1'b0; tick();
        checks++; if ({prd, run} !== 2'b11) begin failures++; $display("FAIL mid_restart got=%b exp=11", {prd, run}); end
        sample_window(20, 1'b0);
        n = count_hi(0, 0, 19) + count_hi(1, 0, 19) + count_hi(2, 0, 19);
        checks++; if (n !== 0) begin failures++; $display("FAIL mid_shadow_cleared got=%0d exp=0", n); end
    endtask

    initial begin
        rst = 1'b1; dutyI = '0; dutyLd = 1'b0; enI = '0; syncI = 1'b0;
        cDuty = '0; cLd = 1'b0; cEn = '0; cSync = 1'b0;
        test_reset();
        test_edge();
        test_duty_update();
        test_sync();
        test_boundary_load();
        test_extremes();
        test_clamp();
        test_center();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
